// File: rtl/dualram_fifo_ctrl.sv
// FWFT FIFO controller around an external 64-entry simple dual-port RAM
// with a registered read port, plus a 2-entry output skid buffer.
module dualram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [6:0]            level,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_enb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [6:0]            ram_cnt;
    logic                  inflight;
    logic [1:0]            skid_cnt;
    logic [DATA_WIDTH-1:0] skid0;
    logic [DATA_WIDTH-1:0] skid1;

    logic       push;
    logic       pop;
    logic       issue;
    logic [6:0] ram_cnt_nxt;
    logic [1:0] skid_cnt_nxt;

    assign wr_ready = !rst && (ram_cnt != 7'd64);
    assign rd_valid = (skid_cnt != 2'd0);
    assign rd_data  = skid0;

    assign push  = wr_valid && wr_ready && !flush;
    assign pop   = rd_valid && rd_ready && !flush;
    // Skid slots plus the pending read never exceed two; a pop frees one slot.
    assign issue = !flush && (ram_cnt != 7'd0) &&
                   (((skid_cnt + 2'(inflight)) < 2'd2) || pop);

    assign ram_ena   = push;
    assign ram_wea   = push;
    assign ram_addra = wr_ptr;
    assign ram_dina  = wr_data;
    assign ram_enb   = issue;
    assign ram_addrb = rd_ptr;

    always_comb begin
        ram_cnt_nxt  = ram_cnt;
        skid_cnt_nxt = skid_cnt;
        case ({push, issue})
            2'b10:   ram_cnt_nxt = ram_cnt + 7'd1;
            2'b01:   ram_cnt_nxt = ram_cnt - 7'd1;
            default: ram_cnt_nxt = ram_cnt;
        endcase
        case ({pop, inflight})
            2'b10:   skid_cnt_nxt = skid_cnt - 2'd1;
            2'b01:   skid_cnt_nxt = skid_cnt + 2'd1;
            default: skid_cnt_nxt = skid_cnt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            skid_cnt <= '0;
            skid0    <= '0;
            skid1    <= '0;
            level    <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            skid_cnt <= '0;
            level    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (issue)
                rd_ptr <= rd_ptr + 1'b1;
            ram_cnt  <= ram_cnt_nxt;
            inflight <= issue;
            skid_cnt <= skid_cnt_nxt;
            level    <= ram_cnt_nxt + 7'(issue) + 7'(skid_cnt_nxt);
            // skid0 is always the oldest word; the RAM result lands behind it.
            case ({pop, inflight})
                2'b10: skid0 <= skid1;
                2'b01: begin
                    if (skid_cnt == 2'd0)
                        skid0 <= ram_doutb;
                    else
                        skid1 <= ram_doutb;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid0 <= ram_doutb;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= ram_doutb;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dualram_fifo_ctrl.sv
// Randomized bench for dualram_fifo_ctrl: an ideal FIFO queue is the reference,
// with a behavioural RAM attached to the controller's RAM ports.
module tb_dualram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic [6:0]  level;
    logic        ram_ena;
    logic        ram_wea;
    logic [5:0]  ram_addra;
    logic [31:0] ram_dina;
    logic        ram_enb;
    logic [5:0]  ram_addrb;
    logic [31:0] ram_doutb;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    logic [31:0] mem [64];
    logic        obs_rv, obs_wr;
    logic [31:0] obs_rd;
    logic        did_push, did_pop;
    logic        hold_pending = 1'b0;
    logic [31:0] held;

    always #5 clk = ~clk;

    dualram_fifo_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .level(level),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
    );

    // Simple dual-port RAM: write port A, registered read port B that holds when idle.
    always @(posedge clk) begin
        if (ram_ena && ram_wea)
            mem[ram_addra] <= ram_dina;
        if (ram_enb)
            ram_doutb <= mem[ram_addrb];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, sample at negedge, update the ideal queue at posedge.
    task automatic tick(input logic wv, input logic [31:0] wd, input logic rr, input logic fl);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        @(negedge clk);
        obs_rv = rd_valid;
        obs_wr = wr_ready;
        obs_rd = rd_data;
        check_eq("level", 32'(level), 32'(q.size()));
        if (q.size() == 0) begin
            check_eq("empty_rv", 32'(rd_valid), 32'd0);
            check_eq("empty_enb", 32'(ram_enb), 32'd0);
        end else if (rd_valid) begin
            check_eq("rd_data", rd_data, q[0]);
        end
        if (q.size() < 64)
            check_eq("wr_ready", 32'(wr_ready), 32'd1);
        if (q.size() >= 66)
            check_eq("full_ready", 32'(wr_ready), 32'd0);
        if (hold_pending) begin
            check_eq("hold_valid", 32'(rd_valid), 32'd1);
            check_eq("hold_data", rd_data, held);
        end
        did_push = wv && wr_ready && !fl;
        did_pop  = rd_valid && rr && !fl;
        check_eq("wea", 32'(ram_wea), 32'(did_push));
        if (fl)
            check_eq("flush_enb", 32'(ram_enb), 32'd0);
        hold_pending = rd_valid && !rr && !fl;
        held = rd_data;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (did_pop)
                void'(q.pop_front());
            if (did_push)
                q.push_back(wd);
        end
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            tick(1'b0, 32'h0, 1'b1, 1'b0);
            n++;
        end
        check_eq("drain_done", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] cur;
        int          acc;
        int          popped;
        int          n;
        logic        seen;

        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
        #1;
        check_eq("rst_rv", 32'(rd_valid), 32'd0);
        check_eq("rst_rd", rd_data, 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
        check_eq("rst_ena", 32'(ram_ena), 32'd0);
        check_eq("rst_enb", 32'(ram_enb), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back writes into an empty FIFO, consumer stalled.
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
            if (i == 2) check_eq("lat_rv_early", 32'(obs_rv), 32'd0);
            if (i == 3) begin
                check_eq("lat_rv", 32'(obs_rv), 32'd1);
                check_eq("lat_data", obs_rd, 32'hA0);
            end
        end
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("level4", 32'(level), 32'd4);
        drain();

        // Continuous stream at full rate across three pointer wraps.
        cur = 0; popped = 0;
        for (int c = 0; c < 203; c++) begin
            tick(cur < 200, cur, 1'b1, 1'b0);
            if (did_push) cur++;
            if (did_pop) popped++;
        end
        check_eq("stream_pops", 32'(popped), 32'd200);
        drain();

        // Fill until stall with the consumer stopped.
        acc = 0;
        for (int c = 0; c < 80; c++) begin
            tick(1'b1, 32'h1000 + 32'(acc), 1'b0, 1'b0);
            if (did_push) acc++;
        end
        check_eq("full_accepted", 32'(acc), 32'd66);
        check_eq("full_level", 32'(level), 32'd66);
        check_eq("full_wr_ready", 32'(wr_ready), 32'd0);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick(1'b0, 32'h0, 1'b0, 1'b0);
            if (obs_wr) seen = 1'b1;
        end
        check_eq("ready_return", 32'(seen), 32'd1);
        drain();

        // Random consumer backpressure with rare flushes, 1000 words.
        cur = $urandom; acc = 0; n = 0;
        while (acc < 1000 && n < 6000) begin
            logic fl;
            fl = ($urandom_range(0, 199) == 0);
            tick(1'b1, cur, 1'($urandom_range(0, 1)), fl);
            if (did_push) begin
                acc++;
                cur = $urandom;
            end
            n++;
        end
        check_eq("rand_done", 32'(acc), 32'd1000);
        drain();

        // Flush with one word in flight and one in the skid, then with a full skid.
        for (int i = 0; i < 5; i++) tick(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("flush_level", 32'(level), 32'd0);
        check_eq("flush_rv", 32'(obs_rv), 32'd0);
        for (int i = 0; i < 5; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b1);
        tick(1'b1, 32'h55, 1'b0, 1'b0);
        n = 0;
        while (!rd_valid && n < 10) begin
            tick(1'b0, 32'h0, 1'b0, 1'b0);
            n++;
        end
        check_eq("post_flush", rd_data, 32'h55);
        drain();

        // Asynchronous reset in the middle of a stream.
        cur = 32'h200;
        for (int c = 0; c < 20; c++) begin
            tick(1'b1, cur, 1'($urandom_range(0, 1)), 1'b0);
            if (did_push) cur++;
        end
        #2 rst = 1'b1;
        #1;
        check_eq("arst_rv", 32'(rd_valid), 32'd0);
        check_eq("arst_level", 32'(level), 32'd0);
        check_eq("arst_enb", 32'(ram_enb), 32'd0);
        check_eq("arst_wea", 32'(ram_wea), 32'd0);
        q.delete();
        hold_pending = 1'b0;
        wr_valid = 1'b0; rd_ready = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        tick(1'b1, 32'h11, 1'b0, 1'b0);
        n = 0;
        while (!rd_valid && n < 10) begin
            tick(1'b0, 32'h0, 1'b0, 1'b0);
            n++;
        end
        check_eq("post_rst", rd_data, 32'h11);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
